// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: host bytes queue in a FIFO and are serialised LSB first on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx_fifo #(
    parameter int SYS_CLK_FREQ    = 100000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx
);
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]         BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]                 r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_count;
    logic                       r_overflow;
    state_t                     r_state;
    logic [CNT_W-1:0]           r_baud;
    logic [2:0]                 r_bit_idx;
    logic [7:0]                 r_shift;
    logic                       r_tx;
`ifdef UART_TX_PARITY_EN
    logic                       r_parity;
`endif

    logic   w_full;
    logic   w_empty;
    logic   w_push;
    logic   w_pop;
    logic   w_baud_done;
    logic   w_shift_en;
    logic   w_tx_nxt;
    state_t w_state_nxt;

    assign w_full      = (r_count == COUNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_push      = wr_en && !w_full;
    assign w_baud_done = (r_baud == BAUD_LAST);

    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);
    assign tx       = r_tx;

    // A write while full is dropped even if the serialiser pops in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (wr_en && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_shift_en = 1'b1;
                        w_tx_nxt   = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Every state change happens on a baud boundary, so one restart rule covers state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            if (r_state == S_IDLE || w_baud_done) r_baud <= '0;
            else                                  r_baud <= r_baud + 1'b1;
            if (r_state != S_DATA)  r_bit_idx <= '0;
            else if (w_baud_done)   r_bit_idx <= r_bit_idx + 1'b1;
            if (w_pop)           r_shift <= r_mem[r_rd_ptr];
            else if (w_shift_en) r_shift <= {1'b0, r_shift[7:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_parity <= 1'b0;
        else if (w_pop) r_parity <= ^r_mem[r_rd_ptr];
    end
`endif

endmodule
